// File: rtl/alu_ctrl_md_if.sv
// Execute-stage bundle between pipeline control and the ALU decode / RV32M sequencer.
interface alu_ctrl_md_if #(
   parameter int XLEN = 32
);
   logic [1:0]      AluOp;
   logic            op5;
   logic            func75;
   logic            func70;
   logic [2:0]      func3;
   logic            valid_i;
   logic            kill_i;
   logic [XLEN-1:0] rs1_i;
   logic [XLEN-1:0] rs2_i;
   logic [3:0]      AluControlPort;
   logic            is_md_o;
   logic            ready_o;
   logic            busy_o;
   logic            done_o;
   logic [XLEN-1:0] result_o;

   modport master (
      output AluOp, op5, func75, func70, func3, valid_i, kill_i, rs1_i, rs2_i,
      input  AluControlPort, is_md_o, ready_o, busy_o, done_o, result_o
   );

   modport slave (
      input  AluOp, op5, func75, func70, func3, valid_i, kill_i, rs1_i, rs2_i,
      output AluControlPort, is_md_o, ready_o, busy_o, done_o, result_o
   );
endinterface

// File: rtl/alu_ctrl_md.sv
// ALU control decode plus a bit-serial RV32M multiply/divide sequencer for the execute stage.
//
// state | meaning
// IDLE  | ready for a new M op
// MUL   | shift-add, one multiplier bit per cycle
// DIV   | restoring divide, one quotient bit per cycle
// DONE  | sign fix-up, result_o/done_o update on exit
module alu_ctrl_md #(
   parameter int XLEN     = 32,
   parameter bit ENABLE_M = 1'b1
) (
   input logic          clk,
   input logic          rst_n,
   alu_ctrl_md_if.slave bus
);
   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t state, state_nxt;

   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   b_q;
   logic [2:0]        op_q;
   logic              neg_q;
   logic [CW-1:0]     cnt;
   logic [XLEN-1:0]   result_q;
   logic              done_q;

   logic              is_md, accept, ready;
   logic              sgn_a, sgn_b, neg, div_zero, ovf, special;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic [XLEN:0]     mul_sum, rem_sh, div_diff;
   logic [2*XLEN-1:0] mul_next, div_next, prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix, fixed;

   // I-type only honours func7[5] for SRAI; otherwise it is immediate bits
   always_comb begin
      bus.AluControlPort = 4'b0000;
      case (bus.AluOp)
         2'b00:   bus.AluControlPort = 4'b0000;
         2'b01:   bus.AluControlPort = 4'b1000;
         default: bus.AluControlPort = {bus.func75 & (bus.op5 | (bus.func3 == 3'b101)), bus.func3};
      endcase
   end

   assign is_md       = ENABLE_M & (bus.AluOp == 2'b10) & bus.op5 & bus.func70;
   assign bus.is_md_o = is_md;
   assign accept      = bus.valid_i & is_md & ready & ~bus.kill_i;

   always_comb begin
      sgn_a = 1'b0;
      sgn_b = 1'b0;
      neg   = 1'b0;
      case (bus.func3)
         3'b001: begin sgn_a = 1'b1; sgn_b = 1'b1; neg = bus.rs1_i[XLEN-1] ^ bus.rs2_i[XLEN-1]; end
         3'b010: begin sgn_a = 1'b1; neg = bus.rs1_i[XLEN-1]; end
         3'b100: begin sgn_a = 1'b1; sgn_b = 1'b1; neg = bus.rs1_i[XLEN-1] ^ bus.rs2_i[XLEN-1]; end
         3'b110: begin sgn_a = 1'b1; sgn_b = 1'b1; neg = bus.rs1_i[XLEN-1]; end
         default: ;
      endcase
      a_mag    = (sgn_a & bus.rs1_i[XLEN-1]) ? -bus.rs1_i : bus.rs1_i;
      b_mag    = (sgn_b & bus.rs2_i[XLEN-1]) ? -bus.rs2_i : bus.rs2_i;
      div_zero = bus.func3[2] & (bus.rs2_i == '0);
      ovf      = bus.func3[2] & ~bus.func3[0] & (bus.rs1_i == MIN_NEG) & (bus.rs2_i == '1);
      special  = div_zero | ovf;
   end

   always_comb begin
      mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : '0);
      mul_next = {mul_sum, acc[XLEN-1:1]};
      rem_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      div_diff = rem_sh - {1'b0, b_q};
      if (!div_diff[XLEN]) div_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else                 div_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
   end

   // acc ends as {high,low} product or {remainder,quotient}
   always_comb begin
      prod_fix = neg_q ? -acc : acc;
      quo_fix  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem_fix  = neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      fixed    = '0;
      case (op_q)
         3'b000:                 fixed = acc[XLEN-1:0];
         3'b001, 3'b010, 3'b011: fixed = prod_fix[2*XLEN-1:XLEN];
         3'b100, 3'b101:         fixed = quo_fix;
         default:                fixed = rem_fix;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) begin
            if (special)           state_nxt = DONE;
            else if (bus.func3[2]) state_nxt = DIV;
            else                   state_nxt = MUL;
         end
         MUL, DIV: begin
            if (bus.kill_i)      state_nxt = IDLE;
            else if (cnt == '0)  state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ready = 1'b0;
      if (state == IDLE) ready = 1'b1;
      bus.ready_o = ready;
      bus.busy_o  = ~ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         cnt      <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               op_q  <= bus.func3;
               neg_q <= neg & ~special;
               b_q   <= b_mag;
               cnt   <= CW'(XLEN-1);
               // special cases preload the final {remainder, quotient} directly
               if (div_zero)  acc <= {bus.rs1_i, {XLEN{1'b1}}};
               else if (ovf)  acc <= {{XLEN{1'b0}}, bus.rs1_i};
               else           acc <= {{XLEN{1'b0}}, a_mag};
            end
            MUL, DIV: if (!bus.kill_i) begin
               acc <= op_q[2] ? div_next : mul_next;
               if (cnt != '0) cnt <= cnt - CW'(1);
            end
            default: begin
               result_q <= fixed;
               done_q   <= 1'b1;
            end
         endcase
      end
   end

   assign bus.done_o   = done_q;
   assign bus.result_o = result_q;
endmodule
